// File: rtl/uart_host_bridge.sv
// Host bus master: turns a valid/ready request stream into timed UART register cycles and returns a response stream.
// Latency: request accept to rsp_valid_o is 1+1+HOLD_CYCLES+RECOVER_CYCLES cycles; irq_o lags ireq_n_i by one cycle.
// Backpressure: one transaction in flight; req_ready_o stays low until the response is taken and any acknowledge is done.
module uart_host_bridge #(
    parameter int HOLD_CYCLES    = 3,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_write_i,
    input  logic [2:0] req_addr_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_write_o,
    input  logic       iack_req_i,
    output logic       iack_done_o,
    output logic       irq_o,
    output logic       chip_sel_n_o,
    output logic [2:0] address_o,
    output logic       read_write_o,
    output logic [7:0] data_o,
    input  logic [7:0] data_i,
    output logic       iack_o,
    input  logic       ireq_n_i
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] REC_LOAD  = 4'(RECOVER_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        ACK_STROBE,
        RECOVER,
        RESP
    } state_t;

    state_t     r_state;
    logic       r_cs_n;
    logic [2:0] r_addr;
    logic       r_rw;
    logic [7:0] r_data;
    logic       r_iack;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic       r_rsp_write;
    logic       r_iack_done;
    logic       r_irq;
    logic       r_iack_pend;
    logic [3:0] r_cnt;
    logic       r_is_write;
    logic       r_is_ack;

    logic       w_req_ready;
    logic       w_accept;

    // A same-cycle acknowledge request blocks acceptance so the acknowledge is served first.
    assign w_req_ready = (r_state == IDLE) & ~r_iack_pend & ~r_rsp_valid & ~iack_req_i;
    assign w_accept    = req_valid_i & w_req_ready;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_cs_n      <= 1'b1;
            r_addr      <= 3'd0;
            r_rw        <= 1'b1;
            r_data      <= 8'd0;
            r_iack      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'd0;
            r_rsp_write <= 1'b0;
            r_iack_done <= 1'b0;
            r_irq       <= 1'b0;
            r_iack_pend <= 1'b0;
            r_cnt       <= 4'd0;
            r_is_write  <= 1'b0;
            r_is_ack    <= 1'b0;
        end else begin
            r_irq       <= ~ireq_n_i;
            r_iack_done <= 1'b0;
            if (iack_req_i) begin
                r_iack_pend <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (r_iack_pend) begin
                        // Requests arriving on the entry edge merge into this acknowledge.
                        r_iack_pend <= 1'b0;
                        r_iack      <= 1'b1;
                        r_is_ack    <= 1'b1;
                        r_cnt       <= HOLD_LOAD;
                        r_state     <= ACK_STROBE;
                    end else if (w_accept) begin
                        r_addr      <= req_addr_i;
                        r_rw        <= ~req_write_i;
                        r_data      <= req_write_i ? req_wdata_i : 8'd0;
                        r_is_write  <= req_write_i;
                        r_is_ack    <= 1'b0;
                        r_rsp_rdata <= 8'd0;
                        r_state     <= SETUP;
                    end
                end

                SETUP: begin
                    r_cs_n  <= 1'b0;
                    r_cnt   <= HOLD_LOAD;
                    r_state <= STROBE;
                end

                STROBE: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_is_write) begin
                            r_rsp_rdata <= data_i;
                        end
                        r_cs_n  <= 1'b1;
                        r_rw    <= 1'b1;
                        r_data  <= 8'd0;
                        r_cnt   <= REC_LOAD;
                        r_state <= RECOVER;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ACK_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_iack      <= 1'b0;
                        r_iack_done <= 1'b1;
                        r_cnt       <= REC_LOAD;
                        r_state     <= RECOVER;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                RECOVER: begin
                    if (r_cnt == 4'd0) begin
                        if (r_is_ack) begin
                            r_state <= IDLE;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_write <= r_is_write;
                            r_state     <= RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = w_req_ready;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_write_o  = r_rsp_write;
    assign iack_done_o  = r_iack_done;
    assign irq_o        = r_irq;
    assign chip_sel_n_o = r_cs_n;
    assign address_o    = r_addr;
    assign read_write_o = r_rw;
    assign data_o       = r_data;
    assign iack_o       = r_iack;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge with a small UART register model and a strobe monitor.
module tb_uart_host_bridge;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       req_valid_i, req_ready_o, req_write_i;
    logic [2:0] req_addr_i;
    logic [7:0] req_wdata_i;
    logic       rsp_valid_o, rsp_ready_i, rsp_write_o;
    logic [7:0] rsp_rdata_o;
    logic       iack_req_i, iack_done_o, irq_o;
    logic       chip_sel_n_o, read_write_o, iack_o, ireq_n_i;
    logic [2:0] address_o;
    logic [7:0] data_o, data_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    uart_host_bridge dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_write_o(rsp_write_o), .iack_req_i(iack_req_i), .iack_done_o(iack_done_o),
        .irq_o(irq_o), .chip_sel_n_o(chip_sel_n_o), .address_o(address_o),
        .read_write_o(read_write_o), .data_o(data_o), .data_i(data_i),
        .iack_o(iack_o), .ireq_n_i(ireq_n_i)
    );

    // UART model: register 5 reads 0x3C, others read their address; bus floats high when deselected.
    always_comb data_i = chip_sel_n_o ? 8'hFF : ((address_o == 3'd5) ? 8'h3C : {5'd0, address_o});

    int   cyc = 0, wr_edges = 0, cs_low = 0, iack_rises = 0, iack_high = 0, done_cnt = 0;
    int   gap = 0, last_gap = 0, last_iack_fall = -1, last_cs_fall = -1;
    logic p_cs = 1'b1, p_iack = 1'b0;
    bit   seen_strobe = 1'b0;

    always @(negedge clk_i) begin
        cyc++;
        if (!chip_sel_n_o) cs_low++;
        if (p_cs && !chip_sel_n_o) begin
            if (!read_write_o) wr_edges++;
            if (seen_strobe) last_gap = gap;
            seen_strobe  = 1'b1;
            last_cs_fall = cyc;
        end
        gap = chip_sel_n_o ? gap + 1 : 0;
        if (!p_iack && iack_o) iack_rises++;
        if (iack_o) iack_high++;
        if (p_iack && !iack_o) last_iack_fall = cyc;
        if (iack_done_o) done_cnt++;
        p_cs   = chip_sel_n_o;
        p_iack = iack_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = 3'd0;
        req_wdata_i = 8'd0; rsp_ready_i = 1'b0; iack_req_i = 1'b0; ireq_n_i = 1'b1;
        repeat (3) tick();
        checks++;
        if ({chip_sel_n_o, read_write_o, address_o, data_o, iack_o} !== {1'b1, 1'b1, 3'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_bus got cs=%b rw=%b a=%h d=%h iack=%b exp cs=1 rw=1 a=0 d=00 iack=0",
                     chip_sel_n_o, read_write_o, address_o, data_o, iack_o);
        end
        checks++;
        if ({rsp_valid_o, rsp_rdata_o, rsp_write_o, iack_done_o, irq_o} !== 12'd0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b rd=%h w=%b done=%b irq=%b exp all 0",
                     rsp_valid_o, rsp_rdata_o, rsp_write_o, iack_done_o, irq_o);
        end
        rst_n_i = 1'b1;
        tick();
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", req_ready_o);
        end
    endtask

    task automatic test_write();
        int cs0;
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 3'd3; req_wdata_i = 8'hA5;
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL wr_ready got %b exp 1", req_ready_o);
        end
        tick();
        req_valid_i = 1'b0;
        cs0 = cs_low;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (rsp_valid_o !== 1'b0) begin
                errors++; $display("FAIL wr_early_valid cycle %0d got %b exp 0", k, rsp_valid_o);
            end
            if (k == 1) begin
                checks++;
                if ({chip_sel_n_o, read_write_o, address_o, data_o} !== {1'b1, 1'b0, 3'd3, 8'hA5}) begin
                    errors++;
                    $display("FAIL wr_setup got cs=%b rw=%b a=%h d=%h exp cs=1 rw=0 a=3 d=a5",
                             chip_sel_n_o, read_write_o, address_o, data_o);
                end
            end else if (k <= 4) begin
                checks++;
                if ({chip_sel_n_o, read_write_o, address_o, data_o} !== {1'b0, 1'b0, 3'd3, 8'hA5}) begin
                    errors++;
                    $display("FAIL wr_strobe cycle %0d got cs=%b rw=%b a=%h d=%h exp cs=0 rw=0 a=3 d=a5",
                             k, chip_sel_n_o, read_write_o, address_o, data_o);
                end
            end else begin
                checks++;
                if ({chip_sel_n_o, read_write_o, data_o} !== {1'b1, 1'b1, 8'h00}) begin
                    errors++;
                    $display("FAIL wr_recover got cs=%b rw=%b d=%h exp cs=1 rw=1 d=00",
                             chip_sel_n_o, read_write_o, data_o);
                end
            end
            tick();
        end
        checks++;
        if ({rsp_valid_o, rsp_write_o, rsp_rdata_o} !== {1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL wr_rsp got v=%b w=%b rd=%h exp v=1 w=1 rd=00", rsp_valid_o, rsp_write_o, rsp_rdata_o);
        end
        checks++;
        if (cs_low - cs0 !== 3) begin
            errors++; $display("FAIL wr_cs_low_cycles got %0d exp 3", cs_low - cs0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checks++;
        if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
            errors++; $display("FAIL wr_consume got v=%b rdy=%b exp v=0 rdy=1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_read();
        int cs0;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 3'd5; req_wdata_i = 8'hEE;
        tick();
        req_valid_i = 1'b0;
        cs0 = cs_low;
        for (int k = 1; k <= 5; k++) begin
            if (k >= 2 && k <= 4) begin
                checks++;
                if ({chip_sel_n_o, read_write_o, address_o, data_o} !== {1'b0, 1'b1, 3'd5, 8'h00}) begin
                    errors++;
                    $display("FAIL rd_strobe cycle %0d got cs=%b rw=%b a=%h d=%h exp cs=0 rw=1 a=5 d=00",
                             k, chip_sel_n_o, read_write_o, address_o, data_o);
                end
            end
            tick();
        end
        checks++;
        if ({rsp_valid_o, rsp_write_o, rsp_rdata_o} !== {1'b1, 1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL rd_rsp got v=%b w=%b rd=%h exp v=1 w=0 rd=3c", rsp_valid_o, rsp_write_o, rsp_rdata_o);
        end
        checks++;
        if (cs_low - cs0 !== 3) begin
            errors++; $display("FAIL rd_cs_low_cycles got %0d exp 3", cs_low - cs0);
        end
        req_valid_i = 1'b1; req_write_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({rsp_valid_o, rsp_rdata_o, req_ready_o} !== {1'b1, 8'h3C, 1'b0}) begin
                errors++;
                $display("FAIL rd_hold cycle %0d got v=%b rd=%h rdy=%b exp v=1 rd=3c rdy=0",
                         i, rsp_valid_o, rsp_rdata_o, req_ready_o);
            end
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_iack_merge();
        int r0, h0, d0;
        r0 = iack_rises; h0 = iack_high; d0 = done_cnt;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 3'd5;
        tick();
        req_valid_i = 1'b0;
        tick();
        iack_req_i = 1'b1; tick(); iack_req_i = 1'b0; tick();
        iack_req_i = 1'b1; tick(); iack_req_i = 1'b0; tick();
        checks++;
        if ({rsp_valid_o, rsp_rdata_o, iack_rises - r0} !== {1'b1, 8'h3C, 32'd0}) begin
            errors++;
            $display("FAIL ia_read_rsp got v=%b rd=%h ack_pulses=%0d exp v=1 rd=3c ack_pulses=0",
                     rsp_valid_o, rsp_rdata_o, iack_rises - r0);
        end
        tick(); tick();
        checks++;
        if ({iack_o, req_ready_o} !== 2'b00) begin
            errors++; $display("FAIL ia_wait_rsp got iack=%b rdy=%b exp 0 0", iack_o, req_ready_o);
        end
        rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
        repeat (12) tick();
        checks++;
        if (iack_rises - r0 !== 1) begin
            errors++; $display("FAIL ia_pulses got %0d exp 1", iack_rises - r0);
        end
        checks++;
        if (iack_high - h0 !== 3) begin
            errors++; $display("FAIL ia_high_cycles got %0d exp 3", iack_high - h0);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++; $display("FAIL ia_done_cycles got %0d exp 1", done_cnt - d0);
        end
        ireq_n_i = 1'b0;
        checks++;
        if (irq_o !== 1'b0) begin
            errors++; $display("FAIL irq_before got %b exp 0", irq_o);
        end
        tick();
        checks++;
        if (irq_o !== 1'b1) begin
            errors++; $display("FAIL irq_assert got %b exp 1", irq_o);
        end
        ireq_n_i = 1'b1;
        tick();
        checks++;
        if (irq_o !== 1'b0) begin
            errors++; $display("FAIL irq_release got %b exp 0", irq_o);
        end
    endtask

    task automatic test_simultaneous();
        int r0, w0;
        bit acc;
        r0 = iack_rises; w0 = wr_edges; acc = 1'b0;
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 3'd1; req_wdata_i = 8'h5A;
        iack_req_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 1'b0) begin
            errors++; $display("FAIL sim_ready got %b exp 0", req_ready_o);
        end
        tick();
        iack_req_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 30 && !acc; i++) begin
            if (req_ready_o) acc = 1'b1;
            tick();
        end
        req_valid_i = 1'b0;
        repeat (10) tick();
        rsp_ready_i = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            errors++; $display("FAIL sim_accept_timeout got %b exp 1", acc);
        end
        checks++;
        if ({iack_rises - r0, wr_edges - w0} !== {32'd1, 32'd1}) begin
            errors++;
            $display("FAIL sim_counts got acks=%0d writes=%0d exp 1 1", iack_rises - r0, wr_edges - w0);
        end
        checks++;
        if (!(last_iack_fall > 0 && last_cs_fall > last_iack_fall)) begin
            errors++;
            $display("FAIL sim_order got iack_fall=%0d cs_fall=%0d exp iack_fall before cs_fall",
                     last_iack_fall, last_cs_fall);
        end
    endtask

    task automatic test_back_to_back();
        int w0, acc;
        w0 = wr_edges; acc = 0;
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 3'd2; req_wdata_i = 8'h11;
        for (int i = 0; i < 40 && acc < 2; i++) begin
            if (req_ready_o) acc++;
            tick();
            if (acc == 1) req_wdata_i = 8'h22;
        end
        req_valid_i = 1'b0;
        repeat (10) tick();
        rsp_ready_i = 1'b0;
        checks++;
        if (acc !== 2) begin
            errors++; $display("FAIL b2b_accepts got %0d exp 2", acc);
        end
        checks++;
        if (wr_edges - w0 !== 2) begin
            errors++; $display("FAIL b2b_write_edges got %0d exp 2", wr_edges - w0);
        end
        checks++;
        if (last_gap < 2) begin
            errors++; $display("FAIL b2b_gap got %0d exp >=2", last_gap);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        bad = 1'b0;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 3'd5;
        tick();
        req_valid_i = 1'b0;
        tick(); tick();
        checks++;
        if (chip_sel_n_o !== 1'b0) begin
            errors++; $display("FAIL rm_in_strobe got cs=%b exp 0", chip_sel_n_o);
        end
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({chip_sel_n_o, iack_o, rsp_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL rm_abort got cs=%b iack=%b v=%b exp cs=1 iack=0 v=0", chip_sel_n_o, iack_o, rsp_valid_o);
        end
        tick();
        rst_n_i = 1'b1;
        tick();
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL rm_ready got %b exp 1", req_ready_o);
        end
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_o || !chip_sel_n_o) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL rm_stale got activity=%b exp 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_iack_merge();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
